imem_program_loader: RTL and testbench
======================================

Name: imem_program_loader

Overview:
- Hardware program loader that writes into the CPU's instruction memory; it replaces the simulation-only preload done by the bench.
- Accepts a byte stream over a valid/ready handshake and packs the bytes into 32-bit big-endian instruction words.
- Writes each word sequentially into instruction memory, then zero-fills every remaining location.
- Raises start_o, which drives the CPU's start_i, once instruction memory is fully initialised.

Parameters:
ADDR_W, 8, instruction-memory word-address width
DEPTH, 256, number of instruction words; must be ≤ 2**ADDR_W and ≥ 2

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous active-high reset
byte_valid_i  input  1  byte_data_i valid
byte_data_i  input  8  program byte, most significant byte of each word first
byte_last_i  input  1  marks final program byte; qualified by byte_valid_i
byte_ready_o  output  1  loader can accept a byte
imem_we_o  output  1  instruction-memory write strobe, one cycle per word
imem_addr_o  output  ADDR_W  word address being written
imem_data_o  output  32  word being written
start_o  output  1  program loaded; CPU may run (level)
words_o  output  ADDR_W+1  number of program words written, excluding zero-fill
overflow_o  output  1  sticky: stream exceeded DEPTH words without byte_last_i

Behaviour:
- Reset (async, any state) clears everything immediately:
  - State = LOAD; byte_ready_o=1.
  - imem_we_o=0, imem_addr_o=0, imem_data_o=0.
  - start_o=0, words_o=0, overflow_o=0.
  - Byte counter and word pointer cleared; any partial word is discarded.
  - Reset mid-load or mid-fill drops start_o; reloading restarts at address 0.
- Handshake:
  - A byte is accepted on a rising edge with byte_valid_i && byte_ready_o.
  - byte_valid_i without ready is ignored; the sender holds the byte.
  - Gaps in valid are allowed and must not corrupt packing.
- Packing:
  - A 2-bit byte counter selects the lane: byte 0 → [31:24], byte 1 → [23:16], byte 2 → [15:8], byte 3 → [7:0].
- Word write:
  - The edge accepting lane 3, or a byte with byte_last_i, registers imem_we_o=1 for exactly one cycle.
  - imem_addr_o = word pointer; imem_data_o = packed word.
  - Write latency: 1 cycle after the accepting edge.
  - Word pointer and words_o increment by 1; the byte counter returns to 0.
  - Unfilled lower lanes of a partial last word are 0.
- State LOAD:
  - byte_ready_o=1, except in the cycle following the write of word DEPTH-1.
  - Last byte accepted and word pointer < DEPTH-1 after its write → FILL.
  - Last byte lands in word DEPTH-1 → DONE.
  - Word DEPTH-1 written without last → DONE and overflow_o=1; no further bytes accepted.
- State FILL:
  - byte_ready_o=0.
  - Each cycle writes imem_we_o=1, data=0, at consecutive addresses up to DEPTH-1.
  - Takes DEPTH - words_o cycles.
  - words_o is not incremented during fill.
  - After writing address DEPTH-1 → DONE.
- State DONE:
  - byte_ready_o=0, imem_we_o=0, start_o=1.
  - Remains until reset; input bytes are ignored.
- start_o is registered and rises on the edge after the final memory write, so memory is complete before the CPU fetches.
- imem_data_o and imem_addr_o hold their last values when imem_we_o=0.
- Transitions LOAD → FILL → DONE are forward only; there is no path back to LOAD except reset.

Test Plan:
- Basic load, DEPTH=256:
  - Stimulus: bytes 8C 08 00 00 01 09 50 20, byte_last_i on the 8th byte.
  - Response: writes addr0=0x8C080000, addr1=0x01095020, then 254 zero writes at addr2..255.
  - start_o rises the cycle after the addr255 write; words_o=2; overflow_o=0.
- Partial word:
  - Stimulus: bytes 11 22 33 44 AA BB, last on the 6th byte.
  - Response: addr0=0x11223344, addr1=0xAABB0000, fill from addr2; words_o=2.
- Valid gaps:
  - Stimulus: the basic-load stream with valid deasserted randomly for 1–3 cycles between bytes.
  - Response: identical memory contents and write order to the basic load.
- Overflow, DEPTH=4:
  - Stimulus: 20 bytes, no last.
  - Response: exactly 4 writes at addr0..3; overflow_o=1; byte_ready_o=0 from the cycle after the addr3 write.
  - start_o=1 with no fill writes; words_o=4.
- Exact fit, DEPTH=4:
  - Stimulus: 16 bytes, last on the 16th byte.
  - Response: 4 writes, no fill; start_o=1; overflow_o=0.
- Reset mid-operation:
  - Stimulus: assert rst_i after 5 bytes and again during FILL.
  - Response: outputs clear immediately and start_o=0.
  - A fresh 4-byte stream DE AD BE EF writes addr0=0xDEADBEEF and the load completes normally.

Source files
------------

// File: rtl/imem_program_loader.sv
// ============================================================================
// Module   : imem_program_loader
// Purpose  : packs a big-endian byte stream into instruction words, zero-fills
//            the rest of instruction memory, then releases the CPU via start_o.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_program_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  input  logic              byte_last_i,
  output logic              byte_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_data_o,
  output logic              start_o,
  output logic [ADDR_W:0]   words_o,
  output logic              overflow_o
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Pointer is one bit wider than the address so DEPTH == 2**ADDR_W is reachable.
  localparam logic [ADDR_W:0] c_last_ptr = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] c_one      = (ADDR_W+1)'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_cnt;
  logic [1:0]        w_cnt_nxt;
  logic [31:0]       r_word;
  logic [31:0]       w_word_nxt;
  logic [ADDR_W:0]   r_ptr;
  logic [ADDR_W:0]   w_ptr_nxt;
  logic [ADDR_W:0]   r_words;
  logic [ADDR_W:0]   w_words_nxt;
  logic              r_we;
  logic              w_we_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [31:0]       r_data;
  logic [31:0]       w_data_nxt;
  logic              r_start;
  logic              w_start_nxt;
  logic              r_ovf;
  logic              w_ovf_nxt;

  logic              w_ready;
  logic              w_acc;
  logic              w_wr;
  logic [31:0]       w_lane;
  logic [31:0]       w_packed;

  assign w_ready  = (r_state == ST_LOAD);
  assign w_acc    = byte_valid_i && w_ready;
  // Byte 0 lands in [31:24]; each later byte moves one lane down.
  assign w_lane   = {byte_data_i, 24'h000000} >> {r_cnt, 3'b000};
  assign w_packed = r_word | w_lane;
  assign w_wr     = w_acc && ((r_cnt == 2'd3) || byte_last_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_word_nxt  = r_word;
    w_ptr_nxt   = r_ptr;
    w_words_nxt = r_words;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_ovf_nxt   = r_ovf;
    // DONE is entered on the final write edge, so start trails that write by one cycle.
    w_start_nxt = r_start || (r_state == ST_DONE);

    case (r_state)
      ST_LOAD: begin
        if (w_acc) begin
          if (w_wr) begin
            w_we_nxt    = 1'b1;
            w_addr_nxt  = r_ptr[ADDR_W-1:0];
            w_data_nxt  = w_packed;
            w_ptr_nxt   = r_ptr + c_one;
            w_words_nxt = r_words + c_one;
            w_cnt_nxt   = 2'd0;
            w_word_nxt  = 32'h0000_0000;
            if (r_ptr == c_last_ptr) begin
              w_state_nxt = ST_DONE;
              w_ovf_nxt   = !byte_last_i;
            end else if (byte_last_i) begin
              w_state_nxt = ST_FILL;
            end
          end else begin
            w_cnt_nxt  = r_cnt + 2'd1;
            w_word_nxt = w_packed;
          end
        end
      end

      ST_FILL: begin
        w_we_nxt   = 1'b1;
        w_addr_nxt = r_ptr[ADDR_W-1:0];
        w_data_nxt = 32'h0000_0000;
        w_ptr_nxt  = r_ptr + c_one;
        if (r_ptr == c_last_ptr) begin
          w_state_nxt = ST_DONE;
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_DONE;
      end

      default: begin
        w_state_nxt = ST_DONE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt   <= 2'd0;
      r_word  <= 32'h0000_0000;
      r_ptr   <= '0;
      r_words <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= 32'h0000_0000;
      r_start <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_word  <= w_word_nxt;
      r_ptr   <= w_ptr_nxt;
      r_words <= w_words_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_start <= w_start_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign byte_ready_o = w_ready;
  assign imem_we_o    = r_we;
  assign imem_addr_o  = r_addr;
  assign imem_data_o  = r_data;
  assign start_o      = r_start;
  assign words_o      = r_words;
  assign overflow_o   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_imem_program_loader.sv
// ============================================================================
// Module   : tb_imem_program_loader
// Purpose  : scoreboard bench for imem_program_loader at DEPTH=256 and DEPTH=4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_program_loader;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: DEPTH=256
  logic        a_rst, a_valid, a_last, a_ready, a_we, a_start, a_ovf;
  logic [7:0]  a_data, a_addr;
  logic [31:0] a_wdata;
  logic [8:0]  a_words;
  // DUT B: DEPTH=4
  logic        b_rst, b_valid, b_last, b_ready, b_we, b_start, b_ovf;
  logic [7:0]  b_data;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;
  logic [2:0]  b_words;

  imem_program_loader #(.ADDR_W(8), .DEPTH(256)) dut_a (
    .clk_i(clk), .rst_i(a_rst), .byte_valid_i(a_valid), .byte_data_i(a_data),
    .byte_last_i(a_last), .byte_ready_o(a_ready), .imem_we_o(a_we),
    .imem_addr_o(a_addr), .imem_data_o(a_wdata), .start_o(a_start),
    .words_o(a_words), .overflow_o(a_ovf)
  );

  imem_program_loader #(.ADDR_W(2), .DEPTH(4)) dut_b (
    .clk_i(clk), .rst_i(b_rst), .byte_valid_i(b_valid), .byte_data_i(b_data),
    .byte_last_i(b_last), .byte_ready_o(b_ready), .imem_we_o(b_we),
    .imem_addr_o(b_addr), .imem_data_o(b_wdata), .start_o(b_start),
    .words_o(b_words), .overflow_o(b_ovf)
  );

  logic [39:0] qa[$];
  logic [39:0] qb[$];
  logic [39:0] a_e, b_e;
  int  a_last_we = -10, b_last_we = -10;
  int  a_start_cyc = 0, b_start_cyc = 0;
  bit  a_start_seen = 0, b_start_seen = 0;

  logic [7:0] basic_bytes [0:7] = '{8'h8C, 8'h08, 8'h00, 8'h00, 8'h01, 8'h09, 8'h50, 8'h20};

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Write monitors: every observed write pops the next expected {addr,data}.
  initial forever begin
    @(negedge clk);
    if (a_we === 1'b1) begin
      total++;
      if (qa.size() == 0) begin
        bad++;
        $display("FAIL a_extra_write got addr=%h data=%h required no write", a_addr, a_wdata);
      end else begin
        a_e = qa.pop_front();
        if ({a_addr, a_wdata} !== a_e) begin
          bad++;
          $display("FAIL a_write got addr=%h data=%h required addr=%h data=%h",
                   a_addr, a_wdata, a_e[39:32], a_e[31:0]);
        end
      end
      a_last_we = cyc;
    end
    if (a_start === 1'b1 && !a_start_seen) begin
      a_start_seen = 1;
      a_start_cyc  = cyc;
    end
  end

  initial forever begin
    @(negedge clk);
    if (b_we === 1'b1) begin
      total++;
      if (qb.size() == 0) begin
        bad++;
        $display("FAIL b_extra_write got addr=%h data=%h required no write", b_addr, b_wdata);
      end else begin
        b_e = qb.pop_front();
        if ({6'b0, b_addr, b_wdata} !== b_e) begin
          bad++;
          $display("FAIL b_write got addr=%h data=%h required addr=%h data=%h",
                   b_addr, b_wdata, b_e[39:32], b_e[31:0]);
        end
      end
      b_last_we = cyc;
    end
    if (b_start === 1'b1 && !b_start_seen) begin
      b_start_seen = 1;
      b_start_cyc  = cyc;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout required completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input bit to_b, input logic [7:0] d, input bit last, output bit ok);
    if (to_b) begin b_valid = 1'b1; b_data = d; b_last = last; end
    else      begin a_valid = 1'b1; a_data = d; a_last = last; end
    ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if ((to_b ? b_ready : a_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    if (to_b) begin b_valid = 1'b0; b_last = 1'b0; end
    else      begin a_valid = 1'b0; a_last = 1'b0; end
  endtask

  task automatic wait_start(input bit to_b, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if ((to_b ? b_start : a_start) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
  endtask

  task automatic pulse_reset(input bit to_b);
    @(posedge clk);
    #2;
    if (to_b) begin b_rst = 1'b1; qb.delete(); b_start_seen = 0; end
    else      begin a_rst = 1'b1; qa.delete(); a_start_seen = 0; end
    @(posedge clk);
    #2;
    if (to_b) b_rst = 1'b0; else a_rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic push_fill_a(input int from);
    for (int i = from; i < 256; i++) qa.push_back({8'(i), 32'h0});
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (a_we !== 1'b0 || a_addr !== 8'h0 || a_wdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_a_write_port got we=%b addr=%h data=%h required 0 0 0", a_we, a_addr, a_wdata);
    end
    total++;
    if (a_start !== 1'b0 || a_words !== 9'd0 || a_ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_a_status got start=%b words=%0d ovf=%b required 0 0 0", a_start, a_words, a_ovf);
    end
    total++;
    if (a_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_a_ready got %b required 1", a_ready);
    end
    total++;
    if ({b_we, b_addr, b_wdata, b_start, b_words, b_ovf, b_ready} !== {1'b0, 2'b0, 32'h0, 1'b0, 3'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_b got we=%b addr=%h data=%h start=%b words=%0d ovf=%b ready=%b required 0 0 0 0 0 0 1",
               b_we, b_addr, b_wdata, b_start, b_words, b_ovf, b_ready);
    end
    @(posedge clk);
    #2;
    a_rst = 1'b0;
    b_rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_done_a(input string nm, input logic [8:0] exp_words);
    bit ok;
    wait_start(1'b0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL %s_start got 0 required 1 (timeout)", nm); end
    total++;
    if (a_words !== exp_words || a_ovf !== 1'b0) begin
      bad++;
      $display("FAIL %s_status got words=%0d ovf=%b required words=%0d ovf=0", nm, a_words, a_ovf, exp_words);
    end
    total++;
    if (qa.size() != 0) begin
      bad++;
      $display("FAIL %s_missing_writes got %0d pending required 0", nm, qa.size());
    end
    total++;
    if (a_start_cyc != a_last_we + 1) begin
      bad++;
      $display("FAIL %s_start_timing got start_cyc=%0d required %0d", nm, a_start_cyc, a_last_we + 1);
    end
    total++;
    if (a_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s_ready_done got %b required 0", nm, a_ready);
    end
  endtask

  task automatic test_basic_load(input bit gaps);
    bit ok;
    string nm;
    nm = gaps ? "gaps" : "basic";
    pulse_reset(1'b0);
    qa.push_back({8'd0, 32'h8C080000});
    qa.push_back({8'd1, 32'h01095020});
    push_fill_a(2);
    for (int i = 0; i < 8; i++) begin
      send_byte(1'b0, basic_bytes[i], i == 7, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL %s_accept byte %0d got no accept required accept", nm, i); end
      if (gaps && i < 7) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    check_done_a(nm, 9'd2);
  endtask

  task automatic test_partial_word();
    bit ok;
    logic [7:0] pb [0:5];
    pb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB};
    pulse_reset(1'b0);
    qa.push_back({8'd0, 32'h11223344});
    qa.push_back({8'd1, 32'hAABB0000});
    push_fill_a(2);
    for (int i = 0; i < 6; i++) begin
      send_byte(1'b0, pb[i], i == 5, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL partial_accept byte %0d got no accept required accept", i); end
    end
    check_done_a("partial", 9'd2);
  endtask

  task automatic test_overflow();
    bit ok;
    pulse_reset(1'b1);
    qb.push_back({8'd0, 32'h10111213});
    qb.push_back({8'd1, 32'h14151617});
    qb.push_back({8'd2, 32'h18191A1B});
    qb.push_back({8'd3, 32'h1C1D1E1F});
    for (int i = 0; i < 16; i++) begin
      send_byte(1'b1, 8'(8'h10 + i), 1'b0, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL ovf_accept byte %0d got no accept required accept", i); end
    end
    b_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      b_data = 8'(8'h20 + k);
      repeat (2) begin
        @(negedge clk);
        total++;
        if (b_ready !== 1'b0) begin
          bad++;
          $display("FAIL ovf_ready byte %0d got %b required 0", 16 + k, b_ready);
        end
      end
    end
    b_valid = 1'b0;
    wait_start(1'b1, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL ovf_start got 0 required 1 (timeout)"); end
    total++;
    if (b_ovf !== 1'b1 || b_words !== 3'd4) begin
      bad++;
      $display("FAIL ovf_status got ovf=%b words=%0d required ovf=1 words=4", b_ovf, b_words);
    end
    total++;
    if (qb.size() != 0) begin
      bad++;
      $display("FAIL ovf_missing_writes got %0d pending required 0", qb.size());
    end
    total++;
    if (b_start_cyc != b_last_we + 1) begin
      bad++;
      $display("FAIL ovf_start_timing got %0d required %0d", b_start_cyc, b_last_we + 1);
    end
  endtask

  task automatic test_exact_fit();
    bit ok;
    pulse_reset(1'b1);
    qb.push_back({8'd0, 32'h00010203});
    qb.push_back({8'd1, 32'h04050607});
    qb.push_back({8'd2, 32'h08090A0B});
    qb.push_back({8'd3, 32'h0C0D0E0F});
    for (int i = 0; i < 16; i++) begin
      send_byte(1'b1, 8'(i), i == 15, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL fit_accept byte %0d got no accept required accept", i); end
    end
    wait_start(1'b1, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL fit_start got 0 required 1 (timeout)"); end
    total++;
    if (b_ovf !== 1'b0 || b_words !== 3'd4) begin
      bad++;
      $display("FAIL fit_status got ovf=%b words=%0d required ovf=0 words=4", b_ovf, b_words);
    end
    total++;
    if (qb.size() != 0 || b_start_cyc != b_last_we + 1) begin
      bad++;
      $display("FAIL fit_completion got pending=%0d start_cyc=%0d required pending=0 start_cyc=%0d",
               qb.size(), b_start_cyc, b_last_we + 1);
    end
  endtask

  task automatic test_reset_midop();
    bit ok;
    logic [7:0] fb [0:3];
    pulse_reset(1'b0);
    qa.push_back({8'd0, 32'h8C080000});
    for (int i = 0; i < 5; i++) begin
      send_byte(1'b0, basic_bytes[i], 1'b0, ok);
    end
    total++;
    if (a_words !== 9'd1) begin
      bad++;
      $display("FAIL midload_words got %0d required 1", a_words);
    end
    #1;
    a_rst = 1'b1;
    #1;
    total++;
    if ({a_we, a_addr, a_wdata, a_start, a_words, a_ovf, a_ready} !== {1'b0, 8'h0, 32'h0, 1'b0, 9'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL midload_reset got we=%b addr=%h data=%h start=%b words=%0d ovf=%b ready=%b required 0 0 0 0 0 0 1",
               a_we, a_addr, a_wdata, a_start, a_words, a_ovf, a_ready);
    end
    @(posedge clk);
    #2;
    a_rst = 1'b0;
    @(posedge clk);
    #1;
    fb = '{8'h11, 8'h22, 8'h33, 8'h44};
    qa.push_back({8'd0, 32'h11223344});
    push_fill_a(1);
    for (int i = 0; i < 4; i++) send_byte(1'b0, fb[i], i == 3, ok);
    repeat (5) @(posedge clk);
    #2;
    a_rst = 1'b1;
    qa.delete();
    #1;
    total++;
    if ({a_we, a_addr, a_wdata, a_start, a_words, a_ready} !== {1'b0, 8'h0, 32'h0, 1'b0, 9'd0, 1'b1}) begin
      bad++;
      $display("FAIL midfill_reset got we=%b addr=%h data=%h start=%b words=%0d ready=%b required 0 0 0 0 0 1",
               a_we, a_addr, a_wdata, a_start, a_words, a_ready);
    end
    @(posedge clk);
    #2;
    a_rst = 1'b0;
    a_start_seen = 0;
    @(posedge clk);
    #1;
    fb = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    qa.push_back({8'd0, 32'hDEADBEEF});
    push_fill_a(1);
    for (int i = 0; i < 4; i++) begin
      send_byte(1'b0, fb[i], i == 3, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL reload_accept byte %0d got no accept required accept", i); end
    end
    check_done_a("reload", 9'd1);
  endtask

  initial begin
    a_rst = 1'b1; a_valid = 1'b0; a_data = 8'h00; a_last = 1'b0;
    b_rst = 1'b1; b_valid = 1'b0; b_data = 8'h00; b_last = 1'b0;
    test_reset();
    test_basic_load(1'b0);
    test_partial_word();
    test_basic_load(1'b1);
    test_overflow();
    test_exact_fit();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
